gpio_in: RTL and testbench
==========================

// Module: gpio_in
// PURPOSE
//   Memory-mapped input port; the read-side counterpart of the core's LED output port.
//   Synchronises and debounces external pins (buttons/switches) and exposes the state to the core.
//   Latches rising edges into sticky flags and raises a level interrupt.
//   Sits on the core's data bus beside the LED register; the address decoder outside drives sel.
// PARAMETERS
//   WIDTH            4     number of input pins
//   DEBOUNCE_CYCLES  1000  stable cycles required before a pin change is accepted (>=2)
// PORTS
//   CLK         in   1      system clock, all state on posedge
//   RESETn      in   1      asynchronous, active-low reset
//   pins        in   WIDTH  raw asynchronous pin inputs
//   sel         in   1      block selected by external address decode
//   mem_addr    in   4      byte offset within block; [1:0] ignored
//   mem_rstrb   in   1      read strobe, one cycle
//   mem_rdata   out  32     read data, registered
//   mem_wdata   in   32     write data
//   mem_wmask   in   4      byte write enables; any bit set = write
//   irq         out  1      level interrupt, |(edge & irq_en)
// BEHAVIOUR
//   Reset (RESETn=0, async): sync FFs, debounced state, edge, irq_en, counters all 0;
//     mem_rdata=0, irq=0. Reset mid-count discards the pending change.
//   Input path: 2-FF synchroniser per pin -> debouncer -> state[WIDTH-1:0].
//   Debouncer per pin: IDLE while sync==state; on mismatch go COUNT, counter=1;
//     each cycle mismatch persists counter++; mismatch gone -> back to IDLE, counter=0;
//     counter==DEBOUNCE_CYCLES-1 while still mismatched -> state<=sync, counter=0, IDLE.
//     Pin-to-state latency: 2 sync cycles + DEBOUNCE_CYCLES cycles.
//   Edge detect: rise[i] = state_next[i] & ~state[i]; edge[i] set the cycle state rises.
//   Register map (mem_addr[3:2]):
//     0 DATA   RO  {0, state}
//     1 EDGE   W1C {0, edge}
//     2 IRQEN  RW  {0, irq_en}; writes take mem_wdata[WIDTH-1:0]
//     3 -      reads 0, writes ignored
//   Read: sel & mem_rstrb in cycle N -> mem_rdata valid at cycle N+1 and held until next
//     read; unselected read leaves mem_rdata unchanged. Upper bits beyond WIDTH read 0.
//   Write: sel & |mem_wmask; effect visible in the next cycle. Writes to DATA ignored.
//   Simultaneous W1C clear and new rise on same bit: set wins (flag stays 1).
//   Simultaneous read and write of EDGE: read returns pre-write value.
//   irq registered: reflects edge/irq_en one cycle after they change.
// CONFIGURATION
//   GPIO_IN_DEBOUNCE_EN defined: debouncer per pin as above.
//   Undefined: debouncer bypassed, state<=sync each cycle (latency 2 + 1 cycles);
//     DEBOUNCE_CYCLES unused; no counters synthesised.
// STRUCTURE
//   Shared include gpio_defs.vh: register offsets GPIO_DATA=0, GPIO_EDGE=1, GPIO_IRQEN=2,
//     debouncer state encodings DB_IDLE/DB_COUNT.
//   Sub-module gpio_debounce (one bit, parameter DEBOUNCE_CYCLES), generate-instantiated
//     WIDTH times; counter width $clog2(DEBOUNCE_CYCLES).
// TESTING
//   1 Reset: hold RESETn=0 with pins=4'hF -> mem_rdata=0, irq=0; read DATA after release
//     before debounce completes -> 0.
//   2 Debounce: pins[0] 0->1 held 1000 cycles (DEBOUNCE_CYCLES=1000) -> DATA=1 exactly
//     2+1000 cycles later; EDGE=1.
//   3 Glitch: pins[1] high for 999 cycles then low -> DATA stays 0, EDGE stays 0.
//   4 IRQ/W1C: IRQEN=4'b0001, rise on pin0 -> irq=1 one cycle after flag; write EDGE=1 ->
//     irq=0 next cycle; clear coincident with new rise -> flag remains 1.
//   5 Map: read offset 3 -> 0; write DATA=0xF -> DATA unchanged; IRQEN write 0xFFFFFFFF
//     -> reads 0x0000000F.
//   6 Reset mid-count: assert RESETn=0 at count 500 -> counters cleared, no rise after release
//     unless pin held a further 1000 cycles. Repeat 2 with GPIO_IN_DEBOUNCE_EN undefined -> DATA=1
//     after 3 cycles.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// Shared definitions for the gpio_in block: register offsets, debouncer
// state encoding and the register-offset decode helper.
package gpio_in_pkg;

  typedef enum logic [1:0] {
    GPIO_DATA  = 2'd0,
    GPIO_EDGE  = 2'd1,
    GPIO_IRQEN = 2'd2,
    GPIO_RSVD  = 2'd3
  } reg_off_e;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

  localparam int RDATA_W = 32;

  // Word offset within the block; byte-lane bits [1:0] do not select anything.
  function automatic reg_off_e reg_decode(input logic [3:0] addr);
    return reg_off_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One-bit debouncer. With GPIO_IN_DEBOUNCE_EN defined a change must persist for
// DEBOUNCE_CYCLES cycles before it is accepted; otherwise it is a plain register.
module gpio_debounce
  import gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic sync_i,
  output logic state_o,
  output logic state_next_o
);

  logic state_q;
  logic state_d;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  db_state_e      st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Debounce state machine: a change is accepted on the cycle the counter hits its last value.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (st_q)
      DB_IDLE: begin
        if (sync_i != state_q) begin
          st_d  = DB_COUNT;
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      DB_COUNT: begin
        if (sync_i == state_q) begin
          st_d  = DB_IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = sync_i;
          st_d    = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        st_d  = DB_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      st_q    <= DB_IDLE;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign state_d = sync_i;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  assign state_o      = state_q;
  assign state_next_o = state_d;

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped debounced input port with sticky rising-edge flags and a level irq.
// Debouncing is built in only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [WIDTH-1:0]   pins,
  input  logic               sel,
  input  logic [3:0]         mem_addr,
  input  logic               mem_rstrb,
  output logic [RDATA_W-1:0] mem_rdata,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wmask,
  output logic               irq
);

  logic [WIDTH-1:0]   sync1_q, sync2_q;
  logic [WIDTH-1:0]   state_q, state_d;
  logic [WIDTH-1:0]   edge_q, edge_d;
  logic [WIDTH-1:0]   irq_en_q, irq_en_d;
  logic [WIDTH-1:0]   clr;
  logic               irq_q;
  logic [RDATA_W-1:0] rdata_q, rdata_d;
  logic [RDATA_W-1:0] rd_val;
  logic               wr_en, rd_en;
  reg_off_e           off;
  logic               unused_bits;

  assign wr_en       = sel & (|mem_wmask);
  assign rd_en       = sel & mem_rstrb;
  assign off         = reg_decode(mem_addr);
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:WIDTH]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .sync_i       (sync2_q[i]),
      .state_o      (state_q[i]),
      .state_next_o (state_d[i])
    );
  end

  // Register write decode; a new rise outranks a same-cycle W1C clear.
  always_comb begin
    clr      = '0;
    irq_en_d = irq_en_q;
    if (wr_en) begin
      case (off)
        GPIO_EDGE:  clr      = mem_wdata[WIDTH-1:0];
        GPIO_IRQEN: irq_en_d = mem_wdata[WIDTH-1:0];
        default:    clr      = '0;
      endcase
    end else begin
      clr = '0;
    end
    edge_d = (edge_q & ~clr) | (state_d & ~state_q);
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rd_val  = '0;
    rdata_d = rdata_q;
    case (off)
      GPIO_DATA:  rd_val[WIDTH-1:0] = state_q;
      GPIO_EDGE:  rd_val[WIDTH-1:0] = edge_q;
      GPIO_IRQEN: rd_val[WIDTH-1:0] = irq_en_q;
      default:    rd_val            = '0;
    endcase
    if (rd_en) begin
      rdata_d = rd_val;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      irq_q    <= |(edge_q & irq_en_q);
      rdata_q  <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_in.sv
// Directed self-checking bench for gpio_in; expected latencies follow GPIO_IN_DEBOUNCE_EN.
module tb_gpio_in;

  localparam int DB = 1000;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int          LAT         = 2 + DB;
  localparam logic [31:0] GLITCH_EDGE = 32'h0;
`else
  localparam int          LAT         = 3;
  localparam logic [31:0] GLITCH_EDGE = 32'h2;
`endif

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [3:0]  pins;
  logic        sel;
  logic [3:0]  mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] d;

  gpio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .pins      (pins),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .irq       (irq)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    sel = 1'b1; mem_addr = a; mem_rstrb = 1'b1;
    step(1);
    v = mem_rdata;
    sel = 1'b0; mem_rstrb = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    sel = 1'b1; mem_addr = a; mem_wdata = v; mem_wmask = 4'hF;
    step(1);
    sel = 1'b0; mem_wmask = 4'h0;
  endtask

  initial begin
    RESETn = 1'b0; pins = 4'hF; sel = 1'b0; mem_addr = 4'h0;
    mem_rstrb = 1'b0; mem_wdata = 32'h0; mem_wmask = 4'h0;

    // 1 reset
    step(3);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    RESETn = 1'b1;
    rd(4'h0, d); check("rst_data_early", d, 32'h0);
    pins = 4'h0; RESETn = 1'b0; step(2); RESETn = 1'b1; step(5);
    rd(4'h8, d); check("rst_irqen", d, 32'h0);
    rd(4'h4, d); check("rst_edge", d, 32'h0);

    // 2 debounce latency, continuous DATA read
    sel = 1'b1; mem_addr = 4'h0; mem_rstrb = 1'b1;
    pins = 4'h1;
    step(LAT);  check("lat_pre", mem_rdata, 32'h0);
    step(1);    check("lat_post", mem_rdata, 32'h1);
    sel = 1'b0; mem_rstrb = 1'b0;
    rd(4'h4, d); check("lat_edge", d, 32'h1);

    // 3 glitch on pin1
    wr(4'h4, 32'hF);
    pins = 4'h3; step(DB - 1); pins = 4'h1; step(DB + 100);
    rd(4'h0, d); check("glitch_data", d, 32'h1);
    rd(4'h4, d); check("glitch_edge", d, GLITCH_EDGE);

    // 4 irq and W1C
    pins = 4'h0; step(LAT + 5);
    wr(4'h4, 32'hF); wr(4'h8, 32'h1); step(1);
    check("irq_idle", {31'b0, irq}, 32'h0);
    rd(4'h0, d); check("fall_data", d, 32'h0);
    pins = 4'h1;
    step(LAT);  check("irq_flag_cycle", {31'b0, irq}, 32'h0);
    step(1);    check("irq_set", {31'b0, irq}, 32'h1);
    rd(4'h4, d); check("irq_edge", d, 32'h1);
    wr(4'h4, 32'h1); check("irq_hold", {31'b0, irq}, 32'h1);
    step(1);         check("irq_clr", {31'b0, irq}, 32'h0);
    pins = 4'h0; step(LAT + 5);
    pins = 4'h1; step(LAT - 1);
    wr(4'h4, 32'h1);
    rd(4'h4, d); check("set_wins", d, 32'h1);
    sel = 1'b1; mem_addr = 4'h4; mem_rstrb = 1'b1; mem_wdata = 32'h1; mem_wmask = 4'h1;
    step(1);
    sel = 1'b0; mem_rstrb = 1'b0; mem_wmask = 4'h0;
    check("rw_edge_pre", mem_rdata, 32'h1);
    rd(4'h4, d); check("rw_edge_post", d, 32'h0);

    // 5 register map
    rd(4'hC, d); check("map_rsvd", d, 32'h0);
    wr(4'h0, 32'hF);
    rd(4'h0, d); check("map_data_ro", d, 32'h1);
    wr(4'h8, 32'hFFFF_FFFF);
    rd(4'h8, d); check("map_irqen", d, 32'hF);
    sel = 1'b0; mem_addr = 4'h0; mem_rstrb = 1'b1; step(1); mem_rstrb = 1'b0;
    check("map_unsel_hold", mem_rdata, 32'hF);
    wr(4'h8, 32'h0);

    // 6 reset mid-count
    pins = 4'h0; step(LAT + 5);
    wr(4'h4, 32'hF);
    pins = 4'h1; step(2 + 500);
    RESETn = 1'b0; step(2);
    check("mid_rst_rdata", mem_rdata, 32'h0);
    RESETn = 1'b1;
    sel = 1'b1; mem_addr = 4'h0; mem_rstrb = 1'b1;
    step(LAT);  check("mid_rst_pre", mem_rdata, 32'h0);
    step(1);    check("mid_rst_post", mem_rdata, 32'h1);
    sel = 1'b0; mem_rstrb = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
